// File: rtl/mem_pkg.sv
// Bus command encodings and master FSM states, shared by master and responder.
package mem_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10
  } mem_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

endpackage

// File: rtl/mem_master.sv
// Single-request bus master: one-beat writes, 1..16-beat incrementing read bursts
// against a responder whose read data lags READ/address by one cycle.
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e   state;
  mem_cmd_e cmd;
  logic [3:0] len_q;
  logic [3:0] beat;

  assign mem_cmd   = cmd;
  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE) && !reset;

  // mem_addr doubles as the burst's current address and din as the latched write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= CMD_NOP;
      mem_addr  <= '0;
      din       <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
      len_q     <= '0;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr;
            len_q    <= req_len;
            beat     <= '0;
            if (req_write) begin
              cmd   <= CMD_WRITE;
              din   <= req_wdata;
              state <= WRITE;
            end else begin
              cmd   <= CMD_READ;
              state <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          cmd   <= CMD_NOP;
          din   <= '0;
          state <= IDLE;
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          rsp_rdata <= mem_data;
          rsp_valid <= 1'b1;
          rsp_last  <= (beat == len_q);
          cmd       <= CMD_NOP;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              mem_addr <= mem_addr + ADDR_STEP;
              beat     <= beat + 4'd1;
              cmd      <= CMD_READ;
              state    <= RD_ADDR;
            end
          end
        end
        default: begin
          cmd   <= CMD_NOP;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a 16x256 synchronous RAM responder.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_last;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] din;
  logic [15:0] mem_data;
  logic        busy;

  int errs = 0;
  int checks = 0;
  int acc_cnt = 0;

  logic [15:0] ram [0:255];
  logic [15:0] ram_q;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] exp_q [0:15];

  mem_master #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .din(din), .mem_data(mem_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: bit 8 of the address is ignored, read data registered one cycle.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_cmd == 2'b01) ram[mem_addr[7:0]] <= din;
    ram_q <= ram[mem_addr[7:0]];
  end
  assign mem_data = ram_q;

  always @(posedge clk) if (req_valid && req_ready) acc_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the first negedge after acceptance.
  task automatic start_req(input logic wr, input logic [8:0] a, input logic [15:0] d,
                           input logic [3:0] l);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_len = l;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [8:0] a, input logic [3:0] l);
    logic [8:0] ea;
    int lat;
    start_req(1'b0, a, 16'h0, l);
    for (int b = 0; b <= int'(l); b++) begin
      lat = 1;
      ea = a + 9'(b);
      chk("rd_cmd", mem_cmd, 2'b10);
      chk("rd_addr", mem_addr, ea);
      while (!rsp_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("rd_latency", lat, 3);
      chk("rd_data", rsp_rdata, exp_q[b]);
      chk("rd_last", rsp_last, (b == int'(l)));
      @(negedge clk);
    end
    chk("rd_idle_after", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;
    logic viol;
    int beats;
    int n;
    int base;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
    #1;
    chk("rst_cmd", mem_cmd, 2'b00);
    chk("rst_addr", mem_addr, 9'h0);
    chk("rst_din", din, 16'h0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_last", rsp_last, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_ready_after", req_ready, 1'b1);
    @(negedge clk);

    // Write then read back one beat
    start_req(1'b1, 9'h003, 16'h00A5, 4'd0);
    chk("wr_cmd", mem_cmd, 2'b01);
    chk("wr_addr", mem_addr, 9'h003);
    chk("wr_din", din, 16'h00A5);
    chk("wr_busy", busy, 1'b1);
    chk("wr_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("wr_end_cmd", mem_cmd, 2'b00);
    chk("wr_end_din", din, 16'h0);
    chk("wr_end_ready", req_ready, 1'b1);
    chk("wr_ram", ram[3], 16'h00A5);
    exp_q[0] = 16'h00A5;
    read_burst(9'h003, 4'd0);

    // Four-beat burst
    preload(8'h10, 16'h0001); preload(8'h11, 16'h0002);
    preload(8'h12, 16'h0003); preload(8'h13, 16'h0004);
    exp_q[0] = 16'h0001; exp_q[1] = 16'h0002; exp_q[2] = 16'h0003; exp_q[3] = 16'h0004;
    read_burst(9'h010, 4'd3);

    // Address wrap from 0x1FF
    preload(8'hFF, 16'hBEEF); preload(8'h00, 16'hCAFE);
    exp_q[0] = 16'hBEEF; exp_q[1] = 16'hCAFE;
    read_burst(9'h1FF, 4'd1);

    // Backpressure on beat 1
    preload(8'h20, 16'h1111); preload(8'h21, 16'h2222);
    rsp_ready = 1'b0;
    start_req(1'b0, 9'h020, 16'h0, 4'd1);
    @(negedge clk); @(negedge clk);
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_last", rsp_last, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_rdata, 16'h1111);
      chk("bp_hold_cmd", mem_cmd, 2'b00);
      chk("bp_hold_addr", mem_addr, 9'h020);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_cmd", mem_cmd, 2'b10);
    chk("bp_next_addr", mem_addr, 9'h021);
    chk("bp_next_valid", rsp_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("bp_b2_valid", rsp_valid, 1'b1);
    chk("bp_b2_data", rsp_rdata, 16'h2222);
    chk("bp_b2_last", rsp_last, 1'b1);
    @(negedge clk);
    chk("bp_idle", busy, 1'b0);

    // Reset during RD_DATA of a 16-beat burst
    for (int i = 0; i < 16; i++) preload(8'(8'h40 + i), 16'(16'h0100 + i));
    start_req(1'b0, 9'h040, 16'h0, 4'd15);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cmd", mem_cmd, 2'b00);
    chk("mid_rst_addr", mem_addr, 9'h0);
    chk("mid_rst_din", din, 16'h0);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_last", rsp_last, 1'b0);
    chk("mid_rst_rdata", rsp_rdata, 16'h0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | rsp_valid;
    end
    chk("mid_rst_no_beats", saw_valid, 1'b0);
    chk("mid_rst_idle", busy, 1'b0);
    start_req(1'b1, 9'h005, 16'h0BEE, 4'd0);
    chk("post_rst_wr_cmd", mem_cmd, 2'b01);
    @(negedge clk);
    chk("post_rst_wr_ram", ram[5], 16'h0BEE);
    exp_q[0] = 16'h0BEE;
    read_burst(9'h005, 4'd0);

    // req_valid held through a burst, second request is a write
    preload(8'h30, 16'h3333); preload(8'h31, 16'h4444);
    base = acc_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h030; req_len = 4'd1;
    @(posedge clk); @(negedge clk);
    req_write = 1'b1; req_addr = 9'h007; req_wdata = 16'h1234; req_len = 4'd0;
    viol = 1'b0; beats = 0; n = 0;
    while (mem_cmd != 2'b01 && n < 20) begin
      if (busy && req_ready) viol = 1'b1;
      if (rsp_valid) beats++;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("hold_write_issued", mem_cmd, 2'b01);
    chk("hold_ready_low_busy", viol, 1'b0);
    chk("hold_beats", beats, 2);
    chk("hold_wr_addr", mem_addr, 9'h007);
    repeat (3) @(negedge clk);
    chk("hold_accept_count", acc_cnt - base, 2);
    chk("hold_wr_ram", ram[7], 16'h1234);
    chk("hold_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
